read_fsm: RTL and testbench

//  Read-out side of the keypad matrix calculator; counterpart of the digit write FSM.
//  On a register-select keypress, fetches every element of the selected matrix register from the register file.

---
 rtl/read_fsm.sv | 152 +++++++++++++++
 tb/tb_read_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_fsm.sv
// -----------------------------------------------------------------------------
// read_fsm
//   Read-out side of the keypad matrix calculator. A register-select keypress
//   starts a pass that fetches every element of the selected matrix register,
//   splits each element into tens/ones decimal digits and streams them to the
//   display driver over a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   key_strobe, isreg        keypress qualifier / keypress is a register key
//   reg_sel                  register number, latched on a register keypress
//   rd_en, rd_reg, rd_idx    register-file read request (one-cycle pulse)
//   rd_data                  element data, valid the cycle after rd_en
//   disp_valid, disp_ready   display handshake
//   disp_digit, disp_pos     BCD digit (4'hE = overflow) and {idx, tens/ones}
//   busy, done, ovf          status: not idle / end-of-pass pulse / sticky >99
// -----------------------------------------------------------------------------
module read_fsm #(
    parameter  int DATA_W = 7,
    parameter  int ELEMS  = 4,
    parameter  int REG_W  = 2,
    localparam int IDX_W  = $clog2(ELEMS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_strobe,
    input  logic              isreg,
    input  logic [REG_W-1:0]  reg_sel,
    output logic              rd_en,
    output logic [REG_W-1:0]  rd_reg,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_data,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [3:0]        disp_digit,
    output logic [IDX_W:0]    disp_pos,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_TENS,
        S_ONES,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [REG_W-1:0]    reg_q, reg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   elem_q, elem_d;
    logic                ovf_q, ovf_d;

    logic                elem_over;
    logic                rd_over;
    logic [3:0]          tens_dig;
    logic [3:0]          ones_dig;

    // Digit split is purely combinational off the captured element; the
    // constant divide/modulo by 10 reduces to small logic at these widths.
    always_comb begin
        elem_over = 32'(elem_q) > 32'd99;
        rd_over   = 32'(rd_data) > 32'd99;
        tens_dig  = elem_over ? 4'hE : 4'(32'(elem_q) / 32'd10);
        ones_dig  = elem_over ? 4'hE : 4'(32'(elem_q) % 32'd10);
    end

    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        idx_d      = idx_q;
        elem_d     = elem_q;
        ovf_d      = ovf_q;
        rd_en      = 1'b0;
        disp_valid = 1'b0;
        disp_digit = 4'h0;
        disp_pos   = '0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Only a register key starts a pass; other keys are ignored.
                if (key_strobe && isreg) begin
                    reg_d   = reg_sel;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                rd_en   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // rd_data is only looked at here, one cycle after rd_en.
                elem_d  = rd_data;
                if (rd_over) ovf_d = 1'b1;
                state_d = S_TENS;
            end
            S_TENS: begin
                disp_valid = 1'b1;
                disp_digit = tens_dig;
                disp_pos   = {idx_q, 1'b0};
                if (disp_ready) state_d = S_ONES;
            end
            S_ONES: begin
                disp_valid = 1'b1;
                disp_digit = ones_dig;
                disp_pos   = {idx_q, 1'b1};
                if (disp_ready) begin
                    // idx stops at the last element; it never wraps in a pass.
                    if (idx_q == IDX_W'(ELEMS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            reg_q   <= '0;
            idx_q   <= '0;
            elem_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            idx_q   <= idx_d;
            elem_q  <= elem_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rd_reg = reg_q;
    assign rd_idx = idx_q;
    assign busy   = (state_q != S_IDLE);
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_read_fsm.sv
// -----------------------------------------------------------------------------
// tb_read_fsm
//   Self-checking bench for read_fsm. A register-file model answers rd_en,
//   a queue of expected {pos,digit} pairs is built from the element values
//   with plain /10 and %10 arithmetic, and a negedge monitor scores every
//   display transfer, read request and handshake hold.
// -----------------------------------------------------------------------------
module tb_read_fsm;
    localparam int DATA_W = 7;
    localparam int ELEMS  = 4;
    localparam int REG_W  = 2;
    localparam int IDX_W  = $clog2(ELEMS);

    logic              clk = 1'b0;
    logic              rst;
    logic              key_strobe;
    logic              isreg;
    logic [REG_W-1:0]  reg_sel;
    logic              rd_en;
    logic [REG_W-1:0]  rd_reg;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              disp_valid;
    logic              disp_ready;
    logic [3:0]        disp_digit;
    logic [IDX_W:0]    disp_pos;
    logic              busy;
    logic              done;
    logic              ovf;

    always #5 clk = ~clk;

    read_fsm #(.DATA_W(DATA_W), .ELEMS(ELEMS), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .key_strobe(key_strobe), .isreg(isreg),
        .reg_sel(reg_sel), .rd_en(rd_en), .rd_reg(rd_reg), .rd_idx(rd_idx),
        .rd_data(rd_data), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_digit(disp_digit), .disp_pos(disp_pos), .busy(busy),
        .done(done), .ovf(ovf)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [DATA_W-1:0] mem [4][ELEMS];
    int                cur_vals [ELEMS];
    int                exp_q [$];
    logic [REG_W-1:0]  exp_reg;
    int                rd_cnt;

    function automatic bit over_upto(input int k);
        bit r = 0;
        for (int i = 0; i <= k; i++) if (cur_vals[i] > 99) r = 1;
        return r;
    endfunction

    // Register file: answers a read the cycle after rd_en, garbage otherwise.
    always @(posedge clk)
        rd_data <= rd_en ? mem[rd_reg][rd_idx] : DATA_W'($urandom);

    // Display-side ready: 0 tied high, 1 random, 2 stall element 1 tens.
    int rdy_mode = 0;
    int stalls   = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: disp_ready = 1'($urandom_range(0, 1));
            2: begin
                if (disp_valid && disp_pos == 3'd2 && stalls > 0) begin
                    disp_ready = 1'b0;
                    stalls--;
                end else disp_ready = 1'b1;
            end
            default: disp_ready = 1'b1;
        endcase
    end

    // ---------------- monitor ----------------
    logic       prev_rst   = 1'b1;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_digit;
    logic [2:0] prev_pos;
    always @(negedge clk) begin
        int e;
        if (!rst && !prev_rst) begin
            if (rd_en) begin
                chk("rd_reg", rd_reg, exp_reg);
                chk("rd_idx", rd_idx, rd_cnt);
                rd_cnt++;
            end
            if (prev_stall) begin
                chk("hold_valid", disp_valid, 1);
                chk("hold_digit", disp_digit, prev_digit);
                chk("hold_pos", disp_pos, prev_pos);
            end
            if (disp_valid && disp_ready) begin
                if (exp_q.size() == 0) chk("extra_xfer", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("digit", disp_digit, e & 15);
                    chk("pos", disp_pos, e >> 4);
                    chk("ovf_xfer", ovf, over_upto(e >> 5));
                end
            end
        end
        prev_rst   = rst;
        prev_stall = disp_valid && !disp_ready;
        prev_digit = disp_digit;
        prev_pos   = disp_pos;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the expected digit stream for register r.
    task automatic load_exp(input logic [REG_W-1:0] r);
        exp_reg = r;
        rd_cnt  = 0;
        exp_q.delete();
        for (int i = 0; i < ELEMS; i++) begin
            cur_vals[i] = int'(mem[r][i]);
            if (cur_vals[i] > 99) begin
                exp_q.push_back(((2*i) << 4) | 14);
                exp_q.push_back(((2*i+1) << 4) | 14);
            end else begin
                exp_q.push_back(((2*i) << 4) | (cur_vals[i] / 10));
                exp_q.push_back(((2*i+1) << 4) | (cur_vals[i] % 10));
            end
        end
    endtask

    // One full pass. exp_c: expected done cycle relative to the strobe edge
    // (0 = not timed). inj: cycle at which a busy-time keypress is injected.
    task automatic run_pass(input logic [REG_W-1:0] r, input int exp_c, input int inj);
        int c;
        int first_v;
        bit got_done;
        bit any_over;
        load_exp(r);
        key_strobe = 1'b1; isreg = 1'b1; reg_sel = r;
        tick();
        key_strobe = 1'b0; isreg = 1'b0; reg_sel = REG_W'($urandom);
        c = 1;
        chk("start_rd_en", rd_en, 1);
        chk("start_busy", busy, 1);
        chk("start_ovf_clr", ovf, 0);
        first_v  = 0;
        got_done = 0;
        while (!got_done && c < 400) begin
            if (disp_valid && first_v == 0) first_v = c;
            if (done) got_done = 1;
            else begin
                if (c == inj) begin
                    key_strobe = 1'b1; isreg = 1'b1; reg_sel = 2'd1;
                end else begin
                    key_strobe = 1'b0; isreg = 1'b0;
                end
                tick();
                c++;
            end
        end
        key_strobe = 1'b0; isreg = 1'b0;
        any_over = over_upto(ELEMS - 1);
        chk("done_seen", got_done, 1);
        chk("first_valid_cycle", first_v, 3);
        if (exp_c != 0) chk("done_cycle", c, exp_c);
        chk("ovf_at_done", ovf, any_over);
        chk("rd_en_count", rd_cnt, ELEMS);
        chk("digits_left", exp_q.size(), 0);
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1; key_strobe = 1'b0; isreg = 1'b0; reg_sel = '0; disp_ready = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < ELEMS; i++) mem[r][i] = DATA_W'($urandom_range(0, 99));
        mem[2][0] = 7'd12; mem[2][1] = 7'd0;   mem[2][2] = 7'd99; mem[2][3] = 7'd7;
        mem[3][0] = 7'd50; mem[3][1] = 7'd105; mem[3][2] = 7'd3;  mem[3][3] = 7'd88;
        repeat (3) tick();
        chk("rst_rd_en", rd_en, 0);      chk("rst_valid", disp_valid, 0);
        chk("rst_done", done, 0);        chk("rst_busy", busy, 0);
        chk("rst_digit", disp_digit, 0); chk("rst_pos", disp_pos, 0);
        chk("rst_rd_reg", rd_reg, 0);    chk("rst_rd_idx", rd_idx, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // basic pass, ready tied high
        rdy_mode = 0;
        run_pass(2'd2, 4*ELEMS+1, 0);
        // three stall cycles in element 1 tens
        rdy_mode = 2; stalls = 3;
        run_pass(2'd2, 4*ELEMS+1+3, 0);
        // overflow element
        rdy_mode = 0;
        run_pass(2'd3, 4*ELEMS+1, 0);
        // busy-time keypress ignored; also shows ovf cleared by the new pass
        run_pass(2'd2, 4*ELEMS+1, 6);

        // non-register key in IDLE
        key_strobe = 1'b1; isreg = 1'b0; reg_sel = 2'd3;
        tick();
        key_strobe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("nonreg_rd_en", rd_en, 0);
            chk("nonreg_busy", busy, 0);
            tick();
        end

        // reset in ONES of element 2 of an overflowing register
        load_exp(2'd3);
        key_strobe = 1'b1; isreg = 1'b1; reg_sel = 2'd3;
        tick();
        key_strobe = 1'b0; isreg = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (disp_valid && disp_pos == 3'd5) found = 1;
            else tick();
        end
        chk("reach_ones_e2", found, 1);
        chk("ovf_before_rst", ovf, 1);
        rst = 1'b1;
        tick();
        chk("mid_rd_en", rd_en, 0);      chk("mid_valid", disp_valid, 0);
        chk("mid_done", done, 0);        chk("mid_busy", busy, 0);
        chk("mid_digit", disp_digit, 0); chk("mid_pos", disp_pos, 0);
        chk("mid_rd_reg", rd_reg, 0);    chk("mid_rd_idx", rd_idx, 0);
        chk("mid_ovf", ovf, 0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        run_pass(2'd2, 4*ELEMS+1, 0);

        // randomized passes with random ready and contents
        rdy_mode = 1;
        for (int p = 0; p < 8; p++) begin
            logic [REG_W-1:0] r;
            r = REG_W'($urandom_range(0, 3));
            for (int i = 0; i < ELEMS; i++) mem[r][i] = DATA_W'($urandom_range(0, 127));
            run_pass(r, 0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
